jtframe_credits_ctrl: RTL and testbench

VRAM access controller for the credits/pause overlay. It shares the overlay's single message-VRAM write/read port between an external host channel (OSD/HPS writes and readback) and an internal fill engine that clears or floods the 1024-word page. It also gates the overlay `enable` so the screen is never shown half-filled. It sits between the host logic and the overlay's `vram_din/vram_addr/vram_we/vram_dout` port.

---
 rtl/jtframe_credits_pkg.sv | 18 +
 rtl/jtframe_credits_fill.sv | 48 ++++
 rtl/jtframe_credits_ctrl.sv | 155 +++++++++++++++
 tb/tb_jtframe_credits_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_credits_pkg.sv
// Shared types and constants for the credits overlay VRAM controller.
// Used by jtframe_credits_ctrl and jtframe_credits_fill.
package jtframe_credits_pkg;

    localparam int CREDITS_VRAM_AW = 10;
    localparam int CREDITS_VRAM_DW = 9;

    localparam logic [CREDITS_VRAM_AW-1:0] CREDITS_LAST_ADDR = 10'h3FF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HWR,
        ST_HRD,
        ST_HRD_WAIT,
        ST_FILL
    } credits_state_e;

endpackage

// File: rtl/jtframe_credits_fill.sv
// Page-fill engine: start edge detector, fill-word latch, address counter and busy/done flags.
// The controller advances it with step, once per word actually written.
module jtframe_credits_fill
    import jtframe_credits_pkg::*;
#(
    parameter int DW = CREDITS_VRAM_DW
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [DW-1:0]              char_in,
    input  logic                       step,
    output logic                       busy,
    output logic                       done,
    output logic [CREDITS_VRAM_AW-1:0] cnt,
    output logic [DW-1:0]              word
);

    logic start_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            word    <= '0;
        end else begin
            start_q <= start;
            done    <= 1'b0;
            if (!busy) begin
                // A start edge during a fill is dropped and the word is not re-latched
                if (start && !start_q) begin
                    busy <= 1'b1;
                    word <= char_in;
                    cnt  <= '0;
                end
            end else if (step) begin
                cnt <= cnt + 1'b1;
                if (cnt == CREDITS_LAST_ADDR) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/jtframe_credits_ctrl.sv
// Credits overlay VRAM access controller: shares the VRAM port between host accesses and the page fill.
// The fill engine and the enable gating are present only when JTFRAME_CREDITS_FILL_EN is defined.
module jtframe_credits_ctrl
    import jtframe_credits_pkg::*;
#(
    parameter int AW = CREDITS_VRAM_AW,
    parameter int DW = CREDITS_VRAM_DW
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_din,
    output logic          host_ack,
    output logic [DW-1:0] host_dout,
    input  logic          fill_start,
    input  logic [DW-1:0] fill_char,
    output logic          fill_busy,
    output logic          fill_done,
    input  logic          show,
    output logic          credits_en,
    output logic [AW-1:0] vram_addr,
    output logic [DW-1:0] vram_din,
    output logic          vram_we,
    input  logic [DW-1:0] vram_dout
);

    credits_state_e state, next_state;

    logic          vram_we_nxt;
    logic [AW-1:0] vram_addr_nxt;
    logic [DW-1:0] vram_din_nxt;
    logic          host_ack_nxt;
    logic [DW-1:0] host_dout_nxt;

`ifdef JTFRAME_CREDITS_FILL_EN
    logic                       last_host;
    logic [CREDITS_VRAM_AW-1:0] fill_cnt;
    logic [DW-1:0]              fill_word;

    jtframe_credits_fill #(.DW(DW)) u_fill (
        .clk     (clk),
        .rst     (rst),
        .start   (fill_start),
        .char_in (fill_char),
        .step    (state == ST_FILL),
        .busy    (fill_busy),
        .done    (fill_done),
        .cnt     (fill_cnt),
        .word    (fill_word)
    );
`else
    logic unused_fill;
    assign unused_fill = ^{fill_start, fill_char};
    assign fill_busy   = 1'b0;
    assign fill_done   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
`ifdef JTFRAME_CREDITS_FILL_EN
            last_host <= 1'b0;
`endif
        end else begin
            state <= next_state;
`ifdef JTFRAME_CREDITS_FILL_EN
            if (state == ST_IDLE) begin
                if (next_state == ST_HWR || next_state == ST_HRD)
                    last_host <= 1'b1;
                else if (next_state == ST_FILL)
                    last_host <= 1'b0;
            end
`endif
        end
    end

    // host_ack is still high in the IDLE cycle after a read; that cycle must not re-grant the same request
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
`ifdef JTFRAME_CREDITS_FILL_EN
                if (host_req && !host_ack && !(last_host && fill_busy))
                    next_state = host_we ? ST_HWR : ST_HRD;
                else if (fill_busy)
                    next_state = ST_FILL;
`else
                if (host_req && !host_ack)
                    next_state = host_we ? ST_HWR : ST_HRD;
`endif
            end
            ST_HWR:      next_state = ST_IDLE;
            ST_HRD:      next_state = ST_HRD_WAIT;
            ST_HRD_WAIT: next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    // Port values are decoded from next_state so they appear in the cycle the state is entered
    always_comb begin
        vram_we_nxt   = 1'b0;
        vram_addr_nxt = vram_addr;
        vram_din_nxt  = vram_din;
        host_ack_nxt  = 1'b0;
        host_dout_nxt = host_dout;
        case (next_state)
            ST_HWR: begin
                vram_we_nxt   = 1'b1;
                vram_addr_nxt = host_addr;
                vram_din_nxt  = host_din;
                host_ack_nxt  = 1'b1;
            end
            ST_HRD: begin
                vram_addr_nxt = host_addr;
            end
`ifdef JTFRAME_CREDITS_FILL_EN
            ST_FILL: begin
                vram_we_nxt   = 1'b1;
                vram_addr_nxt = AW'(fill_cnt);
                vram_din_nxt  = fill_word;
            end
`endif
            default: ;
        endcase
        if (state == ST_HRD_WAIT) begin
            host_ack_nxt  = 1'b1;
            host_dout_nxt = vram_dout;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vram_we    <= 1'b0;
            vram_addr  <= '0;
            vram_din   <= '0;
            host_ack   <= 1'b0;
            host_dout  <= '0;
            credits_en <= 1'b0;
        end else begin
            vram_we    <= vram_we_nxt;
            vram_addr  <= vram_addr_nxt;
            vram_din   <= vram_din_nxt;
            host_ack   <= host_ack_nxt;
            host_dout  <= host_dout_nxt;
`ifdef JTFRAME_CREDITS_FILL_EN
            credits_en <= show && !fill_busy;
`else
            credits_en <= show;
`endif
        end
    end

endmodule

// File: tb/tb_jtframe_credits_ctrl.sv
// Scoreboard bench for jtframe_credits_ctrl with a behavioural VRAM and reference memory.
// Fill scenarios are exercised when JTFRAME_CREDITS_FILL_EN is defined.
`timescale 1ns/1ps
module tb_jtframe_credits_ctrl;

    localparam int AW = 10;
    localparam int DW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          host_req = 1'b0;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_din = '0;
    logic          host_ack;
    logic [DW-1:0] host_dout;
    logic          fill_start = 1'b0;
    logic [DW-1:0] fill_char = '0;
    logic          fill_busy;
    logic          fill_done;
    logic          show = 1'b1;
    logic          credits_en;
    logic [AW-1:0] vram_addr;
    logic [DW-1:0] vram_din;
    logic          vram_we;
    logic [DW-1:0] vram_dout;

    jtframe_credits_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_din   (host_din),
        .host_ack   (host_ack),
        .host_dout  (host_dout),
        .fill_start (fill_start),
        .fill_char  (fill_char),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .show       (show),
        .credits_en (credits_en),
        .vram_addr  (vram_addr),
        .vram_din   (vram_din),
        .vram_we    (vram_we),
        .vram_dout  (vram_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered single-port RAM standing in for the overlay VRAM
    logic [DW-1:0] vram_mem [0:1023];
    always @(posedge clk) begin
        if (vram_we) vram_mem[vram_addr] <= vram_din;
        vram_dout <= vram_mem[vram_addr];
    end

    typedef struct {
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
        int            lat;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem [0:1023];
    bit            ref_valid [0:1023];
    bit            ref_upd = 1'b1;

    int checks = 0;
    int errors = 0;

    int  exp_fill_addr = 0;
    logic [DW-1:0] exp_fill_char = '0;
    int  fill_words = 0;
    int  fill_since_host = 0;
    int  host_grants = 0;
    int  done_cnt = 0;
    int  done_cyc = 0;
    int  fs_cyc = 0;
    bit  fill_running = 1'b0;
    bit  contend = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {host_ack, host_dout, fill_busy, fill_done, credits_en, vram_addr, vram_din, vram_we}, 32'd0);
    endtask

    // Monitor: pops the scoreboard on every ack and checks fill writes against the fill model
    always @(negedge clk) begin
        if (!rst) begin
            if (host_ack) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.rd) begin
                        chk("read_data", 32'(host_dout), 32'(e.data));
                    end else begin
                        chk("write_we", 32'(vram_we), 32'd1);
                        chk("write_addr", 32'(vram_addr), 32'(e.addr));
                        chk("write_data", 32'(vram_din), 32'(e.data));
                        if (contend && fill_running && fill_words > 0) begin
                            chk("alternate", 32'(fill_since_host), 32'd1);
                            host_grants++;
                        end
                    end
                    if (e.lat != 0) chk("ack_latency", 32'(cyc - e.cyc), 32'(e.lat));
                end
                fill_since_host = 0;
            end
            if (vram_we && !host_ack) begin
`ifdef JTFRAME_CREDITS_FILL_EN
                chk("fill_addr", 32'(vram_addr), 32'(exp_fill_addr));
                chk("fill_data", 32'(vram_din), 32'(exp_fill_char));
                chk("credits_off_in_fill", 32'(credits_en), 32'd0);
                exp_fill_addr++;
                fill_words++;
                fill_since_host++;
`else
                chk("no_fill_write", 32'd1, 32'd0);
`endif
            end
            if (fill_done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("fill_words_at_done", 32'(fill_words), 32'd1024);
                fill_running = 1'b0;
            end
        end
    end

    task automatic host_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input int lat);
        exp_t e;
        bit   got;
        @(posedge clk); #1;
        e.rd   = !we;
        e.addr = a;
        e.data = we ? d : ref_mem[a];
        e.cyc  = cyc;
        e.lat  = lat;
        exp_q.push_back(e);
        if (we && ref_upd) begin
            ref_mem[a]   = d;
            ref_valid[a] = 1'b1;
        end
        host_req  = 1'b1;
        host_we   = we;
        host_addr = a;
        host_din  = d;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (host_ack) got = 1'b1;
        end
        host_req = 1'b0;
        if (!got) begin
            chk("host_timeout", 32'd0, 32'd1);
            exp_q.delete();
        end
    endtask

    task automatic random_ops(input int n);
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] a;
            logic          we;
            a  = 10'($urandom_range(0, 15) * 61);
            we = 1'($urandom_range(0, 1));
            if (!ref_valid[a]) we = 1'b1;
            host_op(we, a, 9'($urandom), we ? 1 : 3);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    endtask

    task automatic check_show_follow();
        @(posedge clk); #1 show = 1'b0;
        @(negedge clk); chk("credits_en_latency", 32'(credits_en), 32'd1);
        @(negedge clk); chk("credits_en_show_off", 32'(credits_en), 32'd0);
        @(posedge clk); #1 show = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("credits_en_show_on", 32'(credits_en), 32'd1);
    endtask

    task automatic start_fill(input logic [DW-1:0] c);
        @(posedge clk); #1;
        exp_fill_char = c;
        exp_fill_addr = 0;
        fill_words    = 0;
        fill_running  = 1'b1;
        fs_cyc        = cyc;
        fill_char     = c;
        fill_start    = 1'b1;
        @(negedge clk); chk("busy_before_edge", 32'(fill_busy), 32'd0);
        @(posedge clk); #1 fill_start = 1'b0;
        @(negedge clk); chk("busy_after_edge", 32'(fill_busy), 32'd1);
    endtask

    task automatic wait_done(input int prev, input int limit);
        int n;
        n = 0;
        while (done_cnt == prev && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("fill_done_count", 32'(done_cnt), 32'(prev + 1));
        if (done_cnt != prev + 1) fill_running = 1'b0;
    endtask

    task automatic ref_fill(input logic [DW-1:0] c);
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i]   = c;
            ref_valid[i] = 1'b1;
        end
    endtask

    initial begin
        int prev;
        int n;
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i]   = '0;
            ref_valid[i] = 1'b0;
        end

        repeat (3) @(negedge clk);
        chk_all_zero("reset_outputs");
        @(negedge clk) rst = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("credits_en_after_reset", 32'(credits_en), 32'd1);

        host_op(1'b1, 10'h005, 9'h141, 1);
        host_op(1'b1, 10'h3FF, 9'h0AA, 1);
        host_op(1'b0, 10'h3FF, 9'h000, 3);
        host_op(1'b0, 10'h005, 9'h000, 3);
        random_ops(30);
        check_show_follow();

`ifdef JTFRAME_CREDITS_FILL_EN
        // Uncontended fill with an ignored restart part way through
        prev = done_cnt;
        start_fill(9'h020);
        n = 0;
        while (fill_words < 100 && n < 1000) begin @(negedge clk); n++; end
        @(posedge clk); #1 fill_char = 9'h1FF; fill_start = 1'b1;
        @(posedge clk); #1 fill_start = 1'b0;
        wait_done(prev, 5000);
        chk("fill_cycles", 32'(done_cyc - fs_cyc), 32'd2049);
        @(negedge clk); @(negedge clk);
        chk("credits_en_after_fill", 32'(credits_en), 32'd1);
        ref_fill(9'h020);
        random_ops(20);

        // Saturated host writes during a fill
        ref_upd = 1'b0;
        contend = 1'b1;
        host_grants = 0;
        prev = done_cnt;
        start_fill(9'h055);
        n = 0;
        while (fill_running && n < 3000) begin
            host_op(1'b1, 10'($urandom), 9'($urandom), 0);
            n++;
        end
        wait_done(prev, 100);
        chk("contend_host_grants", 32'(host_grants >= 1000), 32'd1);
        contend = 1'b0;
        ref_upd = 1'b1;

        // Reset in the middle of a fill
        prev = done_cnt;
        start_fill(9'h0C3);
        n = 0;
        while (fill_words < 300 && n < 2000) begin @(negedge clk); n++; end
        chk("abort_reached_300", 32'(fill_words), 32'd300);
        rst = 1'b1;
        #1 chk_all_zero("abort_outputs");
        fill_running = 1'b0;
        repeat (4) @(negedge clk);
        chk_all_zero("abort_held");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt), 32'(prev));
        chk("abort_idle", 32'(fill_busy), 32'd0);
        start_fill(9'h0C3);
        wait_done(prev, 5000);
        chk("refill_cycles", 32'(done_cyc - fs_cyc), 32'd2049);
        ref_fill(9'h0C3);
        random_ops(10);
`else
        @(posedge clk); #1 fill_char = 9'h1FF; fill_start = 1'b1;
        @(posedge clk); #1 fill_start = 1'b0;
        repeat (10) @(negedge clk);
        chk("no_fill_busy", 32'(fill_busy), 32'd0);
        chk("no_fill_done", 32'(done_cnt), 32'd0);
        chk("credits_en_is_show", 32'(credits_en), 32'd1);
        random_ops(10);
`endif

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
